// File: rtl/dff4_reg.sv
`default_nettype none
// ============================================================================
// Module      : dff4_reg
// Description : WIDTH-bit D register with synchronous active-high reset.
//               Optional registered change flag with DFF_Q_CHANGED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dff4_reg #(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
`ifdef DFF_Q_CHANGED_EN
    ,
    output logic             q_changed
`endif
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= D;
        end
    end

    assign Q = r_q;

`ifdef DFF_Q_CHANGED_EN
    logic r_q_changed;

    // Compared against the value Q holds before this edge, so the flag is
    // high exactly while Q shows a freshly different value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_changed <= 1'b0;
        end else begin
            r_q_changed <= (D != r_q);
        end
    end

    assign q_changed = r_q_changed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff4_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff4_reg
// Description : Self-checking bench for dff4_reg against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff4_reg;

    logic       clk;
    logic       rst;
    logic [3:0] D;
    logic [3:0] Q;
`ifdef DFF_Q_CHANGED_EN
    logic       q_changed;
`endif

    int errors = 0;
    int checks = 0;

    // Model state: what Q should hold after the most recent edge.
    logic [3:0] m_q;

    dff4_reg #(
        .WIDTH       (4),
        .RESET_VALUE (4'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .D         (D),
        .Q         (Q)
`ifdef DFF_Q_CHANGED_EN
        ,
        .q_changed (q_changed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Drive on the falling edge, then advance to just after the next rising edge.
    task automatic drive(input logic r, input logic [3:0] d);
        @(negedge clk);
        rst = r;
        D   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        D   = 4'hA;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (Q !== 4'h0) begin
                errors++;
                $display("FAIL reset_powerup edge%0d: Q=%h expected 0", i, Q);
            end
`ifdef DFF_Q_CHANGED_EN
            checks++;
            if (q_changed !== 1'b0) begin
                errors++;
                $display("FAIL reset_qchg edge%0d: q_changed=%b expected 0", i, q_changed);
            end
`endif
        end
        m_q = 4'h0;
    endtask

    task automatic test_capture();
        @(negedge clk);
        rst = 1'b0;
        D   = 4'h5;
        #1;
        checks++;
        if (Q !== 4'h0) begin
            errors++;
            $display("FAIL capture_early5: Q=%h expected 0", Q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Q !== 4'h5) begin
            errors++;
            $display("FAIL capture_5: Q=%h expected 5", Q);
        end
        @(negedge clk);
        D = 4'hF;
        #1;
        checks++;
        if (Q !== 4'h5) begin
            errors++;
            $display("FAIL capture_earlyF: Q=%h expected 5", Q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Q !== 4'hF) begin
            errors++;
            $display("FAIL capture_F: Q=%h expected f", Q);
        end
        m_q = 4'hF;
    endtask

    task automatic test_walk();
        logic [3:0] prev;
        prev = m_q;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = 1'b0;
            D   = 4'(i);
            #1;
            checks++;
            if (Q !== prev) begin
                errors++;
                $display("FAIL walk_hold%0d: Q=%h expected %h", i, Q, prev);
            end
            @(posedge clk);
            #1;
            checks++;
            if (Q !== 4'(i)) begin
                errors++;
                $display("FAIL walk_capture%0d: Q=%h expected %h", i, Q, 4'(i));
            end
            prev = 4'(i);
        end
        m_q = prev;
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 4'hC);
        checks++;
        if (Q !== 4'hC) begin
            errors++;
            $display("FAIL midrst_preload: Q=%h expected c", Q);
        end
        drive(1'b1, 4'h7);
        checks++;
        if (Q !== 4'h0) begin
            errors++;
            $display("FAIL midrst_assert: Q=%h expected 0", Q);
        end
        drive(1'b1, 4'hB);
        checks++;
        if (Q !== 4'h0) begin
            errors++;
            $display("FAIL midrst_hold: Q=%h expected 0", Q);
        end
        drive(1'b0, 4'h7);
        checks++;
        if (Q !== 4'h7) begin
            errors++;
            $display("FAIL midrst_release: Q=%h expected 7", Q);
        end
        m_q = 4'h7;
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rst = 1'b0;
        D   = 4'h3;
        #1;
        D   = 4'h9;
        #1;
        checks++;
        if (Q !== m_q) begin
            errors++;
            $display("FAIL glitch_between: Q=%h expected %h", Q, m_q);
        end
        D   = 4'h3;
        @(posedge clk);
        #1;
        checks++;
        if (Q !== 4'h3) begin
            errors++;
            $display("FAIL glitch_capture: Q=%h expected 3", Q);
        end
        m_q = 4'h3;
    endtask

`ifdef DFF_Q_CHANGED_EN
    task automatic test_q_changed();
        logic exp_flags [3];
        exp_flags = '{1'b1, 1'b0, 1'b0};
        drive(1'b1, 4'h6);
        checks++;
        if (q_changed !== 1'b0) begin
            errors++;
            $display("FAIL qchg_reset: q_changed=%b expected 0", q_changed);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h6);
            checks++;
            if (q_changed !== exp_flags[i]) begin
                errors++;
                $display("FAIL qchg_hold%0d: q_changed=%b expected %b", i, q_changed, exp_flags[i]);
            end
        end
        m_q = 4'h6;
    endtask
`endif

    task automatic test_random();
        logic       r;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic       exp_chg;
        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 7) == 0);
            d = 4'($urandom);
            exp_q   = r ? 4'h0 : d;
            exp_chg = r ? 1'b0 : (d != m_q);
            drive(r, d);
            checks++;
            if (Q !== exp_q) begin
                errors++;
                $display("FAIL random%0d: rst=%b D=%h Q=%h expected %h", i, r, d, Q, exp_q);
            end
`ifdef DFF_Q_CHANGED_EN
            checks++;
            if (q_changed !== exp_chg) begin
                errors++;
                $display("FAIL random_qchg%0d: q_changed=%b expected %b", i, q_changed, exp_chg);
            end
`else
            exp_chg = 1'b0;
`endif
            m_q = exp_q;
        end
    endtask

    initial begin
        rst = 1'b1;
        D   = 4'hA;
        m_q = 4'h0;
        test_reset();
        test_capture();
        test_walk();
        test_mid_reset();
        test_glitch();
`ifdef DFF_Q_CHANGED_EN
        test_q_changed();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
